// File: rtl/memoria_instrucao_programavel.sv
// Programmable instruction memory: registered 1-cycle fetch port plus a handshaked
// block-load port driven by a 3-state loader FSM that blocks fetches while it writes.
module memoria_instrucao_programavel #(
    parameter int LARGURA   = 8,
    parameter int END_BITS  = 8,
    parameter int INIT_MODO = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [END_BITS-1:0] Endereco,
    input  logic                LerEn,
    output logic [LARGURA-1:0]  Instrucao,
    output logic                Valido,
    output logic                Ocupado,
    input  logic                CargaInicio,
    input  logic [END_BITS-1:0] CargaBase,
    input  logic [END_BITS:0]   CargaTamanho,
    input  logic [LARGURA-1:0]  CargaDado,
    input  logic                CargaValido,
    output logic                CargaPronto,
    output logic                CargaFim
);

    localparam int PROF = 2 ** END_BITS;

    typedef enum logic [1:0] {
        OCIOSO,
        CARGA,
        CONCLUIDO
    } estado_t;

    // Power-up image: ~i truncated to LARGURA bits equals (2**LARGURA-1 - i) mod 2**LARGURA.
    function automatic logic [PROF-1:0][LARGURA-1:0] conteudo_inicial();
        logic [PROF-1:0][LARGURA-1:0] v;
        for (int i = 0; i < PROF; i++) begin
            v[i] = (INIT_MODO == 0) ? ~LARGURA'(i) : '0;
        end
        return v;
    endfunction

    // The array is deliberately outside the reset domain so loaded words survive a reset.
    logic [PROF-1:0][LARGURA-1:0] mem_q = conteudo_inicial();
    logic [PROF-1:0][LARGURA-1:0] mem_d;

    estado_t             estado_q, estado_d;
    logic [END_BITS-1:0] ptr_q, ptr_d;
    logic [END_BITS:0]   cnt_q, cnt_d;
    logic [LARGURA-1:0]  instr_q, instr_d;
    logic                valido_q, valido_d;
    logic                escreve;

    always_comb begin
        estado_d = estado_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        instr_d  = instr_q;
        valido_d = 1'b0;
        // A reset edge must not commit the word presented during an aborted load.
        escreve  = Reset && (estado_q == CARGA) && CargaValido;

        if (LerEn && (estado_q == OCIOSO)) begin
            instr_d  = mem_q[Endereco];
            valido_d = 1'b1;
        end

        case (estado_q)
            OCIOSO: begin
                if (CargaInicio) begin
                    ptr_d    = CargaBase;
                    cnt_d    = CargaTamanho;
                    estado_d = (CargaTamanho == '0) ? CONCLUIDO : CARGA;
                end
            end
            CARGA: begin
                if (escreve) begin
                    mem_d[ptr_q] = CargaDado;
                    ptr_d        = ptr_q + 1'b1;
                    cnt_d        = cnt_q - 1'b1;
                    if (cnt_q == (END_BITS + 1)'(1)) begin
                        estado_d = CONCLUIDO;
                    end
                end
            end
            CONCLUIDO: estado_d = OCIOSO;
            default:   estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            estado_q <= OCIOSO;
            ptr_q    <= '0;
            cnt_q    <= '0;
            instr_q  <= '0;
            valido_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            valido_q <= valido_d;
        end
        mem_q <= mem_d;
    end

    assign Instrucao   = instr_q;
    assign Valido      = valido_q;
    assign Ocupado     = (estado_q != OCIOSO);
    assign CargaPronto = (estado_q == CARGA);
    assign CargaFim    = (estado_q == CONCLUIDO);

endmodule

// File: tb/tb_memoria_instrucao_programavel.sv
// Directed bench for memoria_instrucao_programavel: default 8x256 build plus a 16x16 build.
module tb_memoria_instrucao_programavel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] endereco;
    logic       ler_en;
    logic [7:0] instrucao;
    logic       valido, ocupado;
    logic       c_inicio;
    logic [7:0] c_base;
    logic [8:0] c_tam;
    logic [7:0] c_dado;
    logic       c_valido, c_pronto, c_fim;

    logic [3:0]  endereco2;
    logic        ler_en2;
    logic [15:0] instrucao2;
    logic        valido2, ocupado2;
    logic        c_inicio2;
    logic [3:0]  c_base2;
    logic [4:0]  c_tam2;
    logic [15:0] c_dado2;
    logic        c_valido2, c_pronto2, c_fim2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memoria_instrucao_programavel dut (
        .Clock(clk), .Reset(rst_n), .Endereco(endereco), .LerEn(ler_en),
        .Instrucao(instrucao), .Valido(valido), .Ocupado(ocupado),
        .CargaInicio(c_inicio), .CargaBase(c_base), .CargaTamanho(c_tam),
        .CargaDado(c_dado), .CargaValido(c_valido), .CargaPronto(c_pronto), .CargaFim(c_fim)
    );

    memoria_instrucao_programavel #(.LARGURA(16), .END_BITS(4), .INIT_MODO(0)) dut2 (
        .Clock(clk), .Reset(rst_n), .Endereco(endereco2), .LerEn(ler_en2),
        .Instrucao(instrucao2), .Valido(valido2), .Ocupado(ocupado2),
        .CargaInicio(c_inicio2), .CargaBase(c_base2), .CargaTamanho(c_tam2),
        .CargaDado(c_dado2), .CargaValido(c_valido2), .CargaPronto(c_pronto2), .CargaFim(c_fim2)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (instrucao !== 8'h00) begin errors++; $display("FAIL reset_instr got %h exp 00", instrucao); end
        checks++; if ({valido, ocupado, c_pronto, c_fim} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {valido, ocupado, c_pronto, c_fim}); end
        checks++; if ({valido2, ocupado2, c_pronto2, c_fim2} !== 4'b0000) begin errors++; $display("FAIL reset_flags2 got %b exp 0000", {valido2, ocupado2, c_pronto2, c_fim2}); end
    endtask

    task automatic test_power_up();
        logic [7:0] a [3];
        logic [7:0] e [3];
        a = '{8'h00, 8'h01, 8'hFF};
        e = '{8'hFF, 8'hFE, 8'h00};
        ler_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            endereco = a[i];
            tick();
            checks++; if ({valido, instrucao} !== {1'b1, e[i]}) begin errors++; $display("FAIL init_fetch[%0d] got v=%b %h exp v=1 %h", i, valido, instrucao, e[i]); end
        end
        ler_en = 1'b0;
        tick();
        checks++; if ({valido, instrucao} !== {1'b0, 8'h00}) begin errors++; $display("FAIL idle_hold got v=%b %h exp v=0 00", valido, instrucao); end
    endtask

    // Starts a load and streams words back-to-back; checks CargaFim right after the last write.
    task automatic load_block(input logic [7:0] base, input logic [8:0] tam, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                              input string nome);
        logic [7:0] d [4];
        d = '{d0, d1, d2, d3};
        c_inicio = 1'b1; c_base = base; c_tam = tam;
        tick();
        c_inicio = 1'b0;
        checks++; if ({ocupado, c_pronto, c_fim} !== 3'b110) begin errors++; $display("FAIL %s_start got %b exp 110", nome, {ocupado, c_pronto, c_fim}); end
        for (int i = 0; i < int'(tam); i++) begin
            c_valido = 1'b1; c_dado = d[i];
            tick();
        end
        c_valido = 1'b0;
        checks++; if ({ocupado, c_pronto, c_fim} !== 3'b101) begin errors++; $display("FAIL %s_fim got %b exp 101", nome, {ocupado, c_pronto, c_fim}); end
        tick();
        checks++; if ({ocupado, c_fim} !== 2'b00) begin errors++; $display("FAIL %s_idle got %b exp 00", nome, {ocupado, c_fim}); end
    endtask

    task automatic fetch4(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                          input string nome);
        logic [7:0] a [4];
        logic [7:0] e [4];
        a = '{a0, a1, a2, a3};
        e = '{e0, e1, e2, e3};
        ler_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            endereco = a[i];
            tick();
            checks++; if ({valido, instrucao} !== {1'b1, e[i]}) begin errors++; $display("FAIL %s[%0d] addr %h got v=%b %h exp v=1 %h", nome, i, a[i], valido, instrucao, e[i]); end
        end
        ler_en = 1'b0;
    endtask

    task automatic test_load();
        load_block(8'h10, 9'd3, 8'hA1, 8'hB2, 8'hC3, 8'h00, "load");
        fetch4(8'h10, 8'h11, 8'h12, 8'h13, 8'hA1, 8'hB2, 8'hC3, 8'hEC, "load_rd");
    endtask

    task automatic test_wrap();
        load_block(8'hFE, 9'd4, 8'h01, 8'h02, 8'h03, 8'h04, "wrap");
        fetch4(8'hFE, 8'hFF, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, "wrap_rd");
    endtask

    task automatic test_stall();
        c_inicio = 1'b1; c_base = 8'h20; c_tam = 9'd3;
        tick();
        c_inicio = 1'b0;
        c_valido = 1'b1; c_dado = 8'h11;
        tick();
        c_valido = 1'b0; c_dado = 8'hEE; ler_en = 1'b1; endereco = 8'h20;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if ({ocupado, c_pronto, c_fim, valido} !== 4'b1100) begin errors++; $display("FAIL stall[%0d] got %b exp 1100", i, {ocupado, c_pronto, c_fim, valido}); end
        end
        ler_en = 1'b0;
        c_valido = 1'b1; c_dado = 8'h22;
        tick();
        c_dado = 8'h33;
        tick();
        c_valido = 1'b0;
        checks++; if (c_fim !== 1'b1) begin errors++; $display("FAIL stall_fim got %b exp 1", c_fim); end
        tick();
        fetch4(8'h20, 8'h21, 8'h22, 8'h23, 8'h11, 8'h22, 8'h33, 8'hDC, "stall_rd");
    endtask

    task automatic test_zero_and_simultaneous();
        ler_en = 1'b1; endereco = 8'h30;
        c_inicio = 1'b1; c_base = 8'h30; c_tam = 9'd0; c_valido = 1'b1; c_dado = 8'h99;
        tick();
        c_inicio = 1'b0;
        checks++; if ({valido, instrucao} !== {1'b1, 8'hCF}) begin errors++; $display("FAIL simul_fetch got v=%b %h exp v=1 cf", valido, instrucao); end
        checks++; if ({ocupado, c_pronto, c_fim} !== 3'b101) begin errors++; $display("FAIL zero_fim got %b exp 101", {ocupado, c_pronto, c_fim}); end
        c_inicio = 1'b1;
        tick();
        c_inicio = 1'b0; c_valido = 1'b0;
        checks++; if ({valido, ocupado, c_fim} !== 3'b000) begin errors++; $display("FAIL zero_refuse got %b exp 000", {valido, ocupado, c_fim}); end
        tick();
        checks++; if ({valido, instrucao, ocupado} !== {1'b1, 8'hCF, 1'b0}) begin errors++; $display("FAIL zero_unchanged got v=%b %h busy=%b exp v=1 cf busy=0", valido, instrucao, ocupado); end
        ler_en = 1'b0;
    endtask

    task automatic test_reset_abort();
        c_inicio = 1'b1; c_base = 8'h40; c_tam = 9'd5;
        tick();
        c_inicio = 1'b0;
        c_valido = 1'b1; c_dado = 8'h51;
        tick();
        c_dado = 8'h52;
        tick();
        c_dado = 8'h53; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; c_valido = 1'b0;
        checks++; if ({instrucao, valido, ocupado, c_pronto, c_fim} !== {8'h00, 4'b0000}) begin errors++; $display("FAIL abort_outputs got %h %b exp 00 0000", instrucao, {valido, ocupado, c_pronto, c_fim}); end
        tick();
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL abort_idle got %b exp 0", ocupado); end
        fetch4(8'h40, 8'h41, 8'h42, 8'h43, 8'h51, 8'h52, 8'hBD, 8'hBC, "abort_rd");
    endtask

    task automatic test_param_build();
        logic [3:0]  a [4];
        logic [15:0] e [4];
        logic [15:0] d [3];
        a = '{4'h0, 4'h1, 4'hF, 4'hE};
        e = '{16'hFFFF, 16'hFFFE, 16'hFFF0, 16'hFFF1};
        ler_en2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            endereco2 = a[i];
            tick();
            checks++; if ({valido2, instrucao2} !== {1'b1, e[i]}) begin errors++; $display("FAIL p16_init[%0d] got v=%b %h exp v=1 %h", i, valido2, instrucao2, e[i]); end
        end
        ler_en2 = 1'b0;
        d = '{16'h1111, 16'h2222, 16'h3333};
        c_inicio2 = 1'b1; c_base2 = 4'hE; c_tam2 = 5'd3;
        tick();
        c_inicio2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c_valido2 = 1'b1; c_dado2 = d[i];
            tick();
        end
        c_valido2 = 1'b0;
        checks++; if ({ocupado2, c_pronto2, c_fim2} !== 3'b101) begin errors++; $display("FAIL p16_fim got %b exp 101", {ocupado2, c_pronto2, c_fim2}); end
        tick();
        e = '{16'h1111, 16'h2222, 16'h3333, 16'hFFFE};
        a = '{4'hE, 4'hF, 4'h0, 4'h1};
        ler_en2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            endereco2 = a[i];
            tick();
            checks++; if ({valido2, instrucao2} !== {1'b1, e[i]}) begin errors++; $display("FAIL p16_rd[%0d] got v=%b %h exp v=1 %h", i, valido2, instrucao2, e[i]); end
        end
        ler_en2 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; endereco = '0; ler_en = 1'b0;
        c_inicio = 1'b0; c_base = '0; c_tam = '0; c_dado = '0; c_valido = 1'b0;
        endereco2 = '0; ler_en2 = 1'b0;
        c_inicio2 = 1'b0; c_base2 = '0; c_tam2 = '0; c_dado2 = '0; c_valido2 = 1'b0;
        test_reset();
        test_power_up();
        test_load();
        test_wrap();
        test_stall();
        test_zero_and_simultaneous();
        test_reset_abort();
        test_param_build();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
